// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle for seq_multiplier.
// Carries tc only when SEQ_MULT_SIGNED_EN is defined.
interface seq_multiplier_if #(
  parameter int WIDTH = 4
) ();
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef SEQ_MULT_SIGNED_EN
  logic               tc;
`endif
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

`ifdef SEQ_MULT_SIGNED_EN
  modport master (output start, output a, output b, output tc,
                  input busy, input done, input p);
  modport slave  (input start, input a, input b, input tc,
                  output busy, output done, output p);
`else
  modport master (output start, output a, output b,
                  input busy, input done, input p);
  modport slave  (input start, input a, input b,
                  output busy, output done, output p);
`endif
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier, WIDTH cycles per product.
// Optional macro SEQ_MULT_SIGNED_EN adds tc for two's-complement operands.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  seq_multiplier_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               accept_s;
  logic               last_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] p_r;
  logic               busy_r;
  logic               done_r;
  logic               tc_r;
  logic [WIDTH:0]     hi_ext_s;
  logic [WIDTH:0]     mc_ext_s;
  logic [WIDTH:0]     sum_s;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.p    = p_r;

  assign last_s = (cnt_r == CNT_W'(1));

  // Next-state logic and start acceptance
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Upper half carries one guard bit: unsigned carry or sign extension.
  assign hi_ext_s = {tc_r & acc_r[2*WIDTH-1], acc_r[2*WIDTH-1:WIDTH]};
  assign mc_ext_s = {tc_r & mcand_r[WIDTH-1], mcand_r};

  // One shift-add step; a signed multiplier MSB weighs negative, so the last step subtracts
  always_comb begin
    sum_s = hi_ext_s;
    if (acc_r[0]) begin
      if (tc_r && last_s) begin
        sum_s = hi_ext_s - mc_ext_s;
      end else begin
        sum_s = hi_ext_s + mc_ext_s;
      end
    end else begin
      sum_s = hi_ext_s;
    end
    acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand, accumulator, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      p_r     <= {(2*WIDTH){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN);
      done_r <= (state_next_s == DONE);
      if (accept_s) begin
        mcand_r <= bus.a;
        acc_r   <= {{WIDTH{1'b0}}, bus.b};
        cnt_r   <= CNT_W'(WIDTH);
      end else if (state_r == RUN) begin
        acc_r <= acc_next_s;
        cnt_r <= cnt_r - CNT_W'(1);
        if (last_s) begin
          p_r <= acc_next_s;
        end
      end
    end
  end

`ifdef SEQ_MULT_SIGNED_EN
  // Signedness is latched together with the operands
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_r <= 1'b0;
    end else if (accept_s) begin
      tc_r <= bus.tc;
    end
  end
`else
  assign tc_r = 1'b0;
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed plus randomized bench for seq_multiplier at WIDTH=4,
// checked against an arithmetic product model.
module tb_seq_multiplier;
  localparam int W = 4;
`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;
  logic [2*W-1:0] exp_p;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Product from plain integer arithmetic, truncated to 2*W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input bit tcv);
    int sx;
    int sy;
    int prod;
    sx = int'(x);
    sy = int'(y);
    if (tcv && SIGNED_BUILD) begin
      if (x[W-1]) sx = sx - (1 << W);
      if (y[W-1]) sy = sy - (1 << W);
    end
    prod = sx * sy;
    return prod[2*W-1:0];
  endfunction

  task automatic set_tc(input bit tcv);
`ifdef SEQ_MULT_SIGNED_EN
    bus.tc = tcv;
`else
    if (tcv) begin end
`endif
  endtask

  // Start an op (from IDLE or DONE); ends in the cycle where done must be high.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit tcv,
                       input bit inject);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    set_tc(tcv);
    tick();
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    set_tc(1'($urandom));
    for (int i = 0; i < W; i++) begin
      check("busy_run", 64'(bus.busy), 64'd1);
      check("done_run", 64'(bus.done), 64'd0);
      check("p_hold_run", 64'(bus.p), 64'(exp_p));
      if (inject && i == 1) begin
        bus.start = 1'b1;
        bus.a = 4'd1;
        bus.b = 4'd1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    exp_p = model(x, y, tcv);
    check("busy_done", 64'(bus.busy), 64'd0);
    check("done_pulse", 64'(bus.done), 64'd1);
    check("product", 64'(bus.p), 64'(exp_p));
  endtask

  task automatic idle_cycle();
    bus.start = 1'b0;
    tick();
    check("busy_idle", 64'(bus.busy), 64'd0);
    check("done_idle", 64'(bus.done), 64'd0);
    check("p_idle", 64'(bus.p), 64'(exp_p));
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    exp_p     = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 4'd0;
    bus.b     = 4'd0;
    set_tc(1'b0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_p", 64'(bus.p), 64'd0);

    do_op(4'd2, 4'd2, 1'b0, 1'b0);
    idle_cycle();
    do_op(4'd15, 4'd14, 1'b0, 1'b1);
    do_op(4'd3, 4'd5, 1'b0, 1'b0);
    idle_cycle();
    do_op(4'd15, 4'd15, 1'b0, 1'b0);
    idle_cycle();
    do_op(4'd0, 4'd9, 1'b0, 1'b0);
    idle_cycle();

    // Reset during the second RUN cycle abandons the operation.
    bus.start = 1'b1;
    bus.a = 4'd7;
    bus.b = 4'd9;
    tick();
    bus.start = 1'b0;
    check("busy_pre_rst", 64'(bus.busy), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_p = '0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_p", 64'(bus.p), 64'd0);
    for (int i = 0; i < 6; i++) idle_cycle();

    // Reset wins over a simultaneous start.
    do_op(4'd6, 4'd7, 1'b0, 1'b0);
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    exp_p = '0;
    check("rst_prio_busy", 64'(bus.busy), 64'd0);
    check("rst_prio_p", 64'(bus.p), 64'd0);
    idle_cycle();

    if (SIGNED_BUILD) begin
      do_op(4'b1000, 4'b0111, 1'b1, 1'b0);
      do_op(4'b1000, 4'b1000, 1'b1, 1'b0);
      do_op(4'b1000, 4'b1000, 1'b0, 1'b0);
      idle_cycle();
    end

    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal values are 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 SHALL have port a, input, WIDTH bits: multiplicand, sampled on the accepted start.
REQ-006 SHALL have port b, input, WIDTH bits: multiplier, sampled on the accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when p becomes valid.
REQ-009 SHALL have port p, output, 2*WIDTH bits: product, registered.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 SHALL accept start only in IDLE or DONE; an accepted start at edge E0 latches a/b, clears the accumulator, loads the iteration counter with WIDTH, and enters RUN.
REQ-012 SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-013 SHALL perform one shift-add step per RUN cycle: if the current multiplier LSB is 1, add the multiplicand to the upper half of the accumulator (WIDTH+1-bit sum keeping the carry), then shift right by 1.
REQ-014 SHALL complete after exactly WIDTH RUN steps: at edge E0+WIDTH load p with the full 2*WIDTH-bit result, assert done for the following cycle only, and enter DONE.
REQ-015 SHALL move from DONE to IDLE on the next edge when start=0, and to RUN (back-to-back) when start=1.
REQ-016 SHALL drive busy=1 exactly in RUN, so busy is high for WIDTH cycles per operation.
REQ-017 SHALL hold p stable from the done pulse until the next completion; p SHALL NOT change during RUN.
REQ-018 SHALL produce an exact product with no overflow for all operand values, including the all-ones operands (2^WIDTH-1)^2.

Reset
REQ-019 SHALL, whenever rst=1 at a rising edge, force state IDLE, busy=0, done=0, p=0, and clear the counter and accumulator, including mid-RUN (the operation is abandoned and no done is produced).
REQ-020 SHALL give rst priority over start at the same edge.

Configuration
REQ-021 SHALL recognise macro SEQ_MULT_SIGNED_EN; when it is defined, an extra input port tc (1 bit) SHALL exist, sampled with a/b, and tc=1 selects two's-complement multiplication (sign-extended partial sums, with the final step subtracting the multiplicand when the multiplier MSB is 1), producing a signed 2*WIDTH-bit p.
REQ-022 SHALL, when SEQ_MULT_SIGNED_EN is undefined, omit port tc and perform unsigned multiplication only; timing SHALL be identical in both builds.

Verification (WIDTH=4)
REQ-023 SHALL verify: rst, then start with a=2, b=2 -> busy for 4 cycles, done pulse once, p=8'h04.
REQ-024 SHALL verify: a=15, b=14 -> p=8'hD2 (210); a=15, b=15 -> p=8'hE1 (225).
REQ-025 SHALL verify: start asserted again during RUN with a=1, b=1 -> ignored, first result p=8'hD2 unchanged; back-to-back start in DONE with a=3, b=5 -> next p=8'h0F after 4 cycles.
REQ-026 SHALL verify: rst asserted in the 2nd RUN cycle -> next cycle busy=0, done=0, p=0, and no done pulse follows.
REQ-027 SHALL verify, in the SEQ_MULT_SIGNED_EN build: tc=1, a=4'b1000 (-8), b=4'b0111 (7) -> p=8'hC8 (-56); tc=1, a=b=4'b1000 -> p=8'h40; tc=0, a=b=4'b1000 -> p=8'h40.
REQ-028 SHALL verify: a=0, b=9 -> p=0 with done asserted at the normal latency (4 cycles after the accepted start).
